// File: rtl/mod_counter_chain_if.sv
// Control and status bundle for mod_counter_chain.
// The master drives the controls; the counter drives the status.
interface mod_counter_chain_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 4
);
    logic                    en;
    logic                    up;
    logic                    clr;
    logic                    load;
    logic [DIGITS*WIDTH-1:0] load_val;
    logic [DIGITS*WIDTH-1:0] cnt;
    logic                    tc;
    logic                    wrap;
    logic                    ovf;

    modport master (
        output en, up, clr, load, load_val,
        input  cnt, tc, wrap, ovf
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output cnt, tc, wrap, ovf
    );
endinterface

// File: rtl/mod_counter_chain.sv
// Cascaded modulo-MODULUS digit counter: up/down, clear, load,
// terminal count for chaining, wrap pulse and sticky overflow.
module mod_counter_chain #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 4
) (
    input logic                clk,
    input logic                rst,
    mod_counter_chain_if.slave bus
);
    localparam int NB = DIGITS * WIDTH;
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(MODULUS);

    logic [NB-1:0]    cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [NB-1:0]    step_v;
    logic [NB-1:0]    load_v;
    logic [WIDTH-1:0] dig;
    logic [WIDTH-1:0] ld;
    logic             carry;
    logic             borrow;
    logic             tc;

    // carry/borrow end up as the all-top / all-zero flags
    always_comb begin
        step_v = '0;
        load_v = '0;
        dig    = '0;
        ld     = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            dig = cnt_q[k*WIDTH +: WIDTH];
            ld  = bus.load_val[k*WIDTH +: WIDTH];
            step_v[k*WIDTH +: WIDTH] = dig;
            if ({1'b0, dig} >= MODV) begin
                if (bus.up ? carry : borrow)
                    step_v[k*WIDTH +: WIDTH] = '0;
            end else if (bus.up) begin
                if (carry)
                    step_v[k*WIDTH +: WIDTH] =
                        (dig == TOP) ? '0 : dig + WIDTH'(1);
            end else begin
                if (borrow)
                    step_v[k*WIDTH +: WIDTH] =
                        (dig == '0) ? TOP : dig - WIDTH'(1);
            end
            load_v[k*WIDTH +: WIDTH] =
                ({1'b0, ld} < MODV) ? ld : '0;
            carry  = carry & (dig == TOP);
            borrow = borrow & (dig == '0);
        end
    end

    assign tc = bus.en & (bus.up ? carry : borrow);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = load_v;
        end else if (bus.en) begin
            cnt_d  = step_v;
            wrap_d = tc;
            ovf_d  = ovf_q | tc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_mod_counter_chain.sv
// Bench for mod_counter_chain: vector table, corner sequences and
// random stimulus against a mixed-radix value model.
module tb_mod_counter_chain;
    localparam int M = 10;
    localparam int W = 4;
    localparam int D = 4;
    localparam int N = 10000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mod_counter_chain_if #(.WIDTH(4), .DIGITS(4)) ba ();
    mod_counter_chain_if #(.WIDTH(3), .DIGITS(2)) bb ();

    mod_counter_chain #(.MODULUS(10), .WIDTH(4), .DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ba)
    );
    mod_counter_chain #(.MODULUS(6), .WIDTH(3), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bb)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        clr, load, en, up;
        logic [15:0] lv;
        logic [15:0] cnt;
        logic        tc, wrap, ovf;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int to_val(input logic [15:0] p);
        int v = 0;
        for (int k = D - 1; k >= 0; k--) begin
            int d = int'(p[k*W +: W]);
            if (d >= M) d = 0;
            v = v * M + d;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_pack(input int v);
        logic [15:0] p = '0;
        int r = v;
        for (int k = 0; k < D; k++) begin
            p[k*W +: W] = W'(r % M);
            r = r / M;
        end
        return p;
    endfunction

    function automatic vec_t mk(input logic c, l, e, u,
                                input logic [15:0] lv, cn,
                                input logic t, w, o);
        vec_t r;
        r.clr = c; r.load = l; r.en = e; r.up = u;
        r.lv = lv; r.cnt = cn; r.tc = t; r.wrap = w; r.ovf = o;
        return r;
    endfunction

    // Called at posedge+1: drive, check tc, take the edge, check state
    task automatic step_a(input logic c, l, e, u, input logic [15:0] lv,
                          input logic [15:0] ecnt,
                          input logic etc, ew, eo, input string nm);
        ba.clr = c; ba.load = l; ba.en = e; ba.up = u; ba.load_val = lv;
        #1;
        chk({nm, "_tc"}, 32'(ba.tc), 32'(etc));
        @(posedge clk); #1;
        chk({nm, "_cnt"}, 32'(ba.cnt), 32'(ecnt));
        chk({nm, "_wrap"}, 32'(ba.wrap), 32'(ew));
        chk({nm, "_ovf"}, 32'(ba.ovf), 32'(eo));
    endtask

    initial begin
        int v;
        int exp_b;
        logic mo, mw, mt;
        logic c, l, e, u;
        logic [15:0] lv;

        ba.clr = 0; ba.load = 0; ba.en = 1; ba.up = 1; ba.load_val = '0;
        bb.clr = 0; bb.load = 0; bb.en = 0; bb.up = 1; bb.load_val = '0;

        // reset held with en high, then counting from zero
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_cnt", 32'(ba.cnt), 32'h0);
            chk("rst_ovf", 32'(ba.ovf), 32'h0);
        end
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            chk("cnt_up", 32'(ba.cnt), 32'(to_pack(i)));
            chk("cnt_up_wrap", 32'(ba.wrap), 32'h0);
        end
        chk("cnt_up_ovf", 32'(ba.ovf), 32'h0);

        tbl[0]  = mk(0, 1, 0, 1, 16'h0999, 16'h0999, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 16'h0000, 16'h1000, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1, 1, 16'h9999, 16'h9999, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 1);
        tbl[4]  = mk(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 1, 16'h0000, 16'h0001, 0, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        tbl[7]  = mk(0, 0, 1, 0, 16'h0000, 16'h9999, 1, 1, 1);
        tbl[8]  = mk(0, 0, 1, 0, 16'h0000, 16'h9998, 0, 0, 1);
        tbl[9]  = mk(0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 1);
        tbl[10] = mk(0, 0, 1, 0, 16'h0000, 16'h0999, 0, 0, 1);
        tbl[11] = mk(0, 1, 0, 1, 16'h12A4, 16'h1204, 0, 0, 1);
        tbl[12] = mk(1, 1, 1, 1, 16'h5555, 16'h0000, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 0);
        tbl[14] = mk(0, 1, 1, 0, 16'h0009, 16'h0009, 1, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 16'h0000, 16'h0009, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, 1, 16'h0000, 16'h0010, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 1, 16'h9999, 16'h9999, 0, 0, 0);
        tbl[19] = mk(1, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 20; i++)
            step_a(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up,
                   tbl[i].lv, tbl[i].cnt, tbl[i].tc, tbl[i].wrap,
                   tbl[i].ovf, $sformatf("vec%0d", i));

        // asynchronous reset between edges
        step_a(0, 1, 0, 1, 16'h0056, 16'h0056, 0, 0, 0, "ld56");
        step_a(0, 0, 1, 1, 16'h0000, 16'h0057, 0, 0, 0, "to57");
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(ba.cnt), 32'h0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cnt", 32'(ba.cnt), 32'h0001);

        // random traffic against the value model
        step_a(1, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, "rnd_clr");
        v = 0; mo = 1'b0;
        for (int i = 0; i < 400; i++) begin
            c = ($urandom % 20) == 0;
            l = ($urandom % 8) == 0;
            e = ($urandom % 4) != 0;
            u = 1'($urandom % 2);
            case ($urandom % 4)
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                2: lv = 16'h9990;
                default: lv = 16'($urandom);
            endcase
            mt = e && (u ? (v == N - 1) : (v == 0));
            mw = 1'b0;
            if (c) begin
                v = 0; mo = 1'b0;
            end else if (l) begin
                v = to_val(lv);
            end else if (e) begin
                mw = mt;
                if (mt) mo = 1'b1;
                v = u ? (v + 1) % N : (v + N - 1) % N;
            end
            step_a(c, l, e, u, lv, to_pack(v), mt, mw, mo, "rnd");
        end
        ba.clr = 0; ba.load = 0; ba.en = 0;

        // MODULUS 6, two 3-bit digits: full cycle then direction toggling
        bb.clr = 1;
        @(posedge clk); #1;
        bb.clr = 0; bb.en = 1; bb.up = 1;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk); #1;
            exp_b = k % 36;
            chk("m6_cnt", 32'(bb.cnt), 32'({3'(exp_b / 6), 3'(exp_b % 6)}));
            chk("m6_wrap", 32'(bb.wrap), 32'(k == 36));
        end
        chk("m6_ovf", 32'(bb.ovf), 32'h1);
        bb.en = 0; bb.load = 1; bb.load_val = 6'o23;
        @(posedge clk); #1;
        chk("m6_load", 32'(bb.cnt), 32'(6'o23));
        bb.load = 0; bb.en = 1;
        for (int i = 0; i < 8; i++) begin
            bb.up = (i % 2) == 0;
            @(posedge clk); #1;
            chk("m6_toggle", 32'(bb.cnt), bb.up ? 32'(6'o24) : 32'(6'o23));
            chk("m6_toggle_wrap", 32'(bb.wrap), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
